// File: rtl/make_reset_multi.sv
// Multi-channel reset generator: async assert, held release in CLK, per-channel
// DST_CLK deassertion synchronizer and ack handshake. Define MAKE_RESET_MULTI_SEQ_EN for ordered release.
module make_reset_multi #(
  parameter int NCHAN    = 4,
  parameter int RSTDELAY = 2,
  parameter int HOLD     = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [NCHAN-1:0] ASSERT_IN,
  output logic [NCHAN-1:0] ASSERT_OUT,
  output logic [NCHAN-1:0] RELEASED,
  input  logic [NCHAN-1:0] DST_CLK,
  output logic [NCHAN-1:0] OUT_RST_N
);

  localparam int CW = $clog2(HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [NCHAN-1:0] src_rst_n;
  logic [NCHAN-1:0] released;
  logic [NCHAN-1:0] ack_sync;
  logic [NCHAN-1:0] release_ok;

  assign ASSERT_OUT = ~src_rst_n;
  assign RELEASED   = released;

`ifdef MAKE_RESET_MULTI_SEQ_EN
  // Channel i may leave HOLD only once channel i-1 has reached RUN.
  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_order
    if (gi == 0) begin : g_first
      assign release_ok[gi] = 1'b1;
    end else begin : g_rest
      assign release_ok[gi] = released[gi-1];
    end
  end
`else
  assign release_ok = '1;
`endif

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    state_t              state;
    logic [CW-1:0]       cnt;
    logic                src_q;
    logic                rel_q;
    logic [RSTDELAY-1:0] sync_q;
    logic [1:0]          ack_q;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state <= ST_ASSERT;
        cnt   <= '0;
        src_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (ASSERT_IN[gi]) begin
        state <= ST_ASSERT;
        cnt   <= '0;
        src_q <= 1'b0;
        rel_q <= 1'b0;
      end else begin
        case (state)
          ST_ASSERT: begin
            state <= ST_HOLD;
            cnt   <= '0;
          end
          ST_HOLD: begin
            // cnt saturates at its last value while release is stalled
            if (cnt == CNT_LAST) begin
              if (release_ok[gi]) begin
                state <= ST_RELEASE;
                src_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (ack_sync[gi]) begin
              state <= ST_RUN;
              rel_q <= 1'b1;
            end
          end
          ST_RUN: begin
            rel_q <= 1'b1;
          end
          default: begin
            state <= ST_ASSERT;
            src_q <= 1'b0;
            rel_q <= 1'b0;
          end
        endcase
      end
    end

    // Destination synchronizer: cleared at once by the source reset, fills with 1s.
    always_ff @(posedge DST_CLK[gi] or negedge src_q) begin
      if (!src_q) begin
        sync_q <= '0;
      end else begin
        sync_q <= (sync_q << 1) | RSTDELAY'(1);
      end
    end

    // Ack back into CLK; clearing on src reset prevents a stale ack releasing early.
    always_ff @(posedge CLK or negedge src_q) begin
      if (!src_q) begin
        ack_q <= '0;
      end else begin
        ack_q <= {ack_q[0], sync_q[RSTDELAY-1]};
      end
    end

    assign src_rst_n[gi] = src_q;
    assign released[gi]  = rel_q;
    assign ack_sync[gi]  = ack_q[1];
    assign OUT_RST_N[gi] = sync_q[RSTDELAY-1];
  end

endmodule

// File: tb/tb_make_reset_multi.sv
// Directed bench for make_reset_multi (NCHAN=2, HOLD=4, RSTDELAY=2); DST clocks
// share the CLK period, rise 2 ns after CLK and can be gated per channel.
module tb_make_reset_multi;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] ASSERT_IN = 2'b00;
  logic [1:0] ASSERT_OUT;
  logic [1:0] RELEASED;
  logic [1:0] DST_CLK;
  logic [1:0] OUT_RST_N;
  logic       dst_base = 1'b0;
  logic [1:0] dst_en = 2'b11;

  int errors = 0;
  int checks = 0;

  make_reset_multi #(
    .NCHAN   (2),
    .RSTDELAY(2),
    .HOLD    (4)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .ASSERT_IN (ASSERT_IN),
    .ASSERT_OUT(ASSERT_OUT),
    .RELEASED  (RELEASED),
    .DST_CLK   (DST_CLK),
    .OUT_RST_N (OUT_RST_N)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2;
    forever #5 dst_base = ~dst_base;
  end

  assign DST_CLK = {2{dst_base}} & dst_en;

  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  // Called at a negedge with RST_N low; releases reset and checks the power-up timeline.
  task automatic power_up(input string tag);
    check({tag, "_rst_aout"}, ASSERT_OUT, 2'b11);
    check({tag, "_rst_rel"},  RELEASED,   2'b00);
    check({tag, "_rst_out"},  OUT_RST_N,  2'b00);
    RST_N = 1'b1;
    edge_n(4);
    check({tag, "_e4_aout"}, ASSERT_OUT, 2'b11);
    edge_n(1);
`ifdef MAKE_RESET_MULTI_SEQ_EN
    check({tag, "_e5_aout"}, ASSERT_OUT, 2'b10);
    check({tag, "_e5_out"},  OUT_RST_N,  2'b00);
    edge_n(1);
    check({tag, "_e6_out"},  OUT_RST_N,  2'b01);
    check({tag, "_e6_rel"},  RELEASED,   2'b00);
    edge_n(3);
    check({tag, "_e9_rel"},  RELEASED,   2'b01);
    check({tag, "_e9_aout"}, ASSERT_OUT, 2'b10);
    edge_n(1);
    check({tag, "_e10_aout"}, ASSERT_OUT, 2'b00);
    edge_n(1);
    check({tag, "_e11_out"}, OUT_RST_N, 2'b11);
    edge_n(3);
    check({tag, "_e14_rel"}, RELEASED, 2'b11);
`else
    check({tag, "_e5_aout"}, ASSERT_OUT, 2'b00);
    check({tag, "_e5_out"},  OUT_RST_N,  2'b00);
    edge_n(1);
    check({tag, "_e6_out"},  OUT_RST_N,  2'b11);
    check({tag, "_e6_rel"},  RELEASED,   2'b00);
    edge_n(2);
    check({tag, "_e8_rel"},  RELEASED,   2'b00);
    edge_n(1);
    check({tag, "_e9_rel"},  RELEASED,   2'b11);
`endif
  endtask

  initial begin
    edge_n(2);
    power_up("pwr");

    // One-cycle request on channel 1 while both run
    edge_n(2);
    ASSERT_IN = 2'b10;
    @(posedge CLK);
    #1;
    check("s2_out_fall",  OUT_RST_N,  2'b01);
    check("s2_aout_rise", ASSERT_OUT, 2'b10);
    @(negedge CLK);
    ASSERT_IN = 2'b00;
    check("s2_rel_drop", RELEASED, 2'b01);
    for (int c = 1; c <= 4; c++) begin
      edge_n(1);
      check("s2_hold_aout", ASSERT_OUT, 2'b10);
      check("s2_hold_out",  OUT_RST_N,  2'b01);
      check("s2_hold_rel",  RELEASED,   2'b01);
    end
    edge_n(1);
    check("s2_e5_aout", ASSERT_OUT, 2'b00);
    edge_n(1);
    check("s2_e6_out", OUT_RST_N, 2'b11);
    edge_n(3);
    check("s2_e9_rel", RELEASED, 2'b11);

    // Channel 0 re-requested one cycle after its source reset rises
    ASSERT_IN = 2'b01;
    edge_n(1);
    ASSERT_IN = 2'b00;
    edge_n(5);
    check("s3_q5_aout", ASSERT_OUT, 2'b00);
    check("s3_q5_out",  OUT_RST_N,  2'b10);
    check("s3_q5_rel",  RELEASED,   2'b10);
    ASSERT_IN = 2'b01;
    edge_n(1);
    ASSERT_IN = 2'b00;
    check("s3_q6_aout", ASSERT_OUT, 2'b01);
    check("s3_q6_out",  OUT_RST_N,  2'b10);
    check("s3_q6_rel",  RELEASED,   2'b10);
    for (int c = 7; c <= 10; c++) begin
      edge_n(1);
      check("s3_rehold_aout", ASSERT_OUT, 2'b01);
      check("s3_rehold_out",  OUT_RST_N,  2'b10);
      check("s3_rehold_rel",  RELEASED,   2'b10);
    end
    edge_n(1);
    check("s3_q11_aout", ASSERT_OUT, 2'b00);
    check("s3_q11_out",  OUT_RST_N,  2'b10);
    edge_n(1);
    check("s3_q12_out", OUT_RST_N, 2'b11);
    edge_n(3);
    check("s3_q15_rel", RELEASED, 2'b11);

    // RST_N pulse while channel 1 holds and channel 0 runs
    ASSERT_IN = 2'b10;
    edge_n(1);
    ASSERT_IN = 2'b00;
    edge_n(2);
    check("s4_hold_aout", ASSERT_OUT, 2'b10);
    RST_N = 1'b0;
    #1;
    check("s4_rst_out",  OUT_RST_N,  2'b00);
    check("s4_rst_rel",  RELEASED,   2'b00);
    check("s4_rst_aout", ASSERT_OUT, 2'b11);
    @(negedge CLK);
    power_up("s4");

    // Destination clock 0 stopped across a full reset
    @(negedge dst_base);
    dst_en = 2'b10;
    @(negedge CLK);
    RST_N = 1'b0;
    edge_n(1);
    check("s5_rst_out", OUT_RST_N, 2'b00);
    RST_N = 1'b1;
    edge_n(9);
`ifdef MAKE_RESET_MULTI_SEQ_EN
    check("s5_stall_aout", ASSERT_OUT, 2'b10);
    check("s5_stall_rel",  RELEASED,   2'b00);
    check("s5_stall_out",  OUT_RST_N,  2'b00);
    edge_n(5);
    check("s5_stall2_aout", ASSERT_OUT, 2'b10);
`else
    check("s5_indep_aout", ASSERT_OUT, 2'b00);
    check("s5_indep_rel",  RELEASED,   2'b10);
    check("s5_indep_out",  OUT_RST_N,  2'b10);
    edge_n(5);
    check("s5_indep2_rel", RELEASED, 2'b10);
`endif
    @(negedge dst_base);
    dst_en = 2'b11;
    @(negedge CLK);
    for (int i = 0; i < 10 && RELEASED[0] !== 1'b1; i++) edge_n(1);
    check("s5_rel0_rise", {1'b0, RELEASED[0]}, 2'b01);
`ifdef MAKE_RESET_MULTI_SEQ_EN
    check("s5_ch1_waits", ASSERT_OUT, 2'b10);
    edge_n(1);
    check("s5_ch1_go", ASSERT_OUT, 2'b00);
    edge_n(1);
    check("s5_ch1_out", OUT_RST_N, 2'b11);
    edge_n(3);
    check("s5_ch1_rel", RELEASED, 2'b11);
`else
    check("s5_both_rel",  RELEASED,   2'b11);
    check("s5_both_aout", ASSERT_OUT, 2'b00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/make_reset_multi.md
# make_reset_multi

Multi-channel reset generator with these behaviours:
- Each of NCHAN channels produces a reset on its own destination clock.
- Assertion of a channel's reset is asynchronous.
- Deassertion follows a programmable minimum hold time in the CLK domain, then an RSTDELAY-deep synchronizer in the destination domain.
- A released handshake returns to the CLK domain once the destination has left reset.

The block sits in platform and infrastructure logic, where one control domain sequences resets into several worker clock domains.

## Interface
- NCHAN, 4: number of reset channels, ≥1.
- RSTDELAY, 2: destination synchronizer depth in DST_CLK flops, ≥1.
- HOLD, 8: minimum source-domain cycles spent in HOLD before release, ≥1.
- CLK  in  1  source/control clock.
- RST_N  in  1  reset, asynchronous, active-low; clock CLK.
- ASSERT_IN  in  NCHAN  per-channel reset request, level, CLK domain.
- ASSERT_OUT  out  NCHAN  1 while the channel's source reset is low (!src_rst_n[i]).
- RELEASED  out  NCHAN  1 when the channel is in RUN (destination deassertion acknowledged).
- DST_CLK  in  NCHAN  per-channel destination clock.
- OUT_RST_N  out  NCHAN  per-channel active-low reset, deasserts synchronous to DST_CLK[i].

## Operation
- **Per-channel FSM (CLK domain)**
  - States: ASSERT, HOLD, RELEASE, RUN.
  - Internal registers: HOLD counter cnt and src_rst_n.
  - ASSERT: src_rst_n=0. If ASSERT_IN[i]=0, go to HOLD with cnt=0.
  - HOLD: src_rst_n=0, cnt increments. At cnt==HOLD-1, go to RELEASE and set src_rst_n=1.
  - RELEASE: src_rst_n=1. When ack_sync[i]=1, go to RUN.
  - RUN: src_rst_n=1, RELEASED[i]=1.
  - ASSERT_IN[i]=1 in any state: go to ASSERT next edge, with cnt=0 and src_rst_n=0. This has priority over every other transition.
- **Destination synchronizer**
  - RSTDELAY flops clocked by DST_CLK[i], asynchronously cleared by src_rst_n[i]=0, shifting in 1.
  - OUT_RST_N[i] is the last stage.
- **Acknowledge path**
  - OUT_RST_N[i] is synchronized into CLK through 2 flops to form ack_sync[i].
  - These flops are asynchronously cleared by src_rst_n[i]=0, so a stale ack cannot release the next cycle.
- **RST_N low**
  - All channels go to ASSERT, cnt=0, src_rst_n=0.
  - Outputs: OUT_RST_N=0 (asynchronously), ASSERT_OUT all 1s, RELEASED all 0s.
- **Widths and counter**
  - cnt width is clog2(HOLD+1).
  - cnt never wraps; it stops at HOLD-1 and saturates there when stalled (see Configuration).
- **Channel independence**
  - Channels are independent except under the Configuration macro.
  - A channel's ASSERT_IN affects only that channel.

## Timing
- Assertion:
  - ASSERT_IN[i] sampled high at edge k: src_rst_n[i]=0 after edge k.
  - OUT_RST_N[i] falls combinationally-asynchronously, with no DST_CLK needed.
  - ASSERT_OUT[i]=1 and RELEASED[i]=0 from edge k.
- Release:
  - ASSERT_IN[i] sampled low at edge k in ASSERT: HOLD entered at edge k.
  - src_rst_n rises at edge k+HOLD, so ASSERT_OUT=0 from k+HOLD.
- Destination:
  - OUT_RST_N[i] rises on the RSTDELAY-th DST_CLK[i] rising edge after src_rst_n rises.
  - An edge coincident with the src_rst_n rise may or may not count.
- RELEASED[i] rises 2–3 CLK edges after OUT_RST_N[i] rises.
- Minimum source reset width is HOLD+1 CLK cycles, including the ASSERT cycle.
- ASSERT_IN re-asserted in RELEASE, before ack:
  - Return to ASSERT.
  - Synchronizer and ack are cleared immediately.
  - RELEASED stays 0.
- ASSERT_IN pulse of one cycle while in RUN:
  - Full sequence: ASSERT for 1 cycle, HOLD for HOLD cycles, then RELEASE.
- RST_N asserted mid-sequence: all channels are forced to ASSERT regardless of state.

## Configuration
- MAKE_RESET_MULTI_SEQ_EN defined (ordered release):
  - A channel i>0 in HOLD with cnt==HOLD-1 stays in HOLD while RELEASED[i-1]=0, with cnt saturated and src_rst_n=0.
  - It enters RELEASE on the first edge where RELEASED[i-1]=1.
  - Channel 0 is unaffected.
  - Only release is ordered. Re-asserting channel i-1 does not disturb a channel i already in RELEASE or RUN.
- Undefined: all channels release independently per the FSM above.

## Test plan
Common settings for all scenarios: NCHAN=2, HOLD=4, RSTDELAY=2, DST_CLK period equal to CLK.
- Power-up with ASSERT_IN=00, RST_N released at edge 0:
  - ASSERT_OUT=11 until edge 5, then 00.
  - OUT_RST_N both rise at the 2nd DST_CLK edge after that.
  - RELEASED=11 within 3 further CLK edges.
- 1-cycle ASSERT_IN[1] pulse while in RUN:
  - OUT_RST_N[1] falls in the same cycle, with no DST_CLK edge.
  - ASSERT_OUT[1] high for 5 cycles.
  - Channel 0 outputs unchanged throughout.
- ASSERT_IN[0] re-asserted one cycle after src_rst_n[0] rises, before ack:
  - RELEASED[0] never pulses.
  - OUT_RST_N[0] stays 0.
  - The hold restarts.
- RST_N pulsed low while channel 1 is in HOLD and channel 0 is in RUN:
  - OUT_RST_N=00 immediately, RELEASED=00.
  - Both channels restart the power-up timing.
- With MAKE_RESET_MULTI_SEQ_EN, DST_CLK[0] stopped:
  - Channel 1 stays in HOLD with ASSERT_OUT[1]=1.
  - When DST_CLK[0] restarts, RELEASED[0] rises, then channel 1 releases on the next edge.
- Without MAKE_RESET_MULTI_SEQ_EN, same stimulus:
  - Channel 1 reaches RELEASED[1]=1 while RELEASED[0]=0.
